// File: rtl/mem_arb_pkg.sv
// Shared types, memType encodings and the LSU access-legality check for mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
    typedef enum logic {REQ_IF = 1'b0, REQ_LS = 1'b1} req_id_t;

    localparam logic [2:0] MT_B  = 3'b000;
    localparam logic [2:0] MT_H  = 3'b001;
    localparam logic [2:0] MT_W  = 3'b010;
    localparam logic [2:0] MT_BU = 3'b100;
    localparam logic [2:0] MT_HU = 3'b101;

    // Unsigned byte/half types only make sense for loads, so a store using them is illegal.
    function automatic logic ls_access_err(input logic we, input logic [2:0] typ,
                                           input logic [1:0] addr_lo);
        logic err;
        err = 1'b0;
        case (typ)
            MT_B:    err = 1'b0;
            MT_H:    err = addr_lo[0];
            MT_W:    err = |addr_lo;
            MT_BU:   err = we;
            MT_HU:   err = we | addr_lo[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant; combinational grant, pointer updates only when a grant is issued.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_id_t last;

    // bit 0 = fetch, bit 1 = LSU; on a tie the side not served last wins
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) gnt = (last == REQ_LS) ? 2'b01 : 2'b10;
            else              gnt = req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    last <= REQ_LS;
        else if (|gnt) last <= gnt[1] ? REQ_LS : REQ_IF;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and LSU: grant in IDLE, hold strobes MEM_LAT cycles,
// then a one-cycle rvalid. Requests arriving outside IDLE wait (gnt low) until the FSM returns.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [2:0]    ls_type,
    input  logic [AW-1:0] ls_addr,
    input  logic [31:0]   ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [31:0]   ls_rdata,
    output logic          ls_err,
    output logic          memRead,
    output logic          memWrite,
    output logic [2:0]    memType,
    output logic [31:0]   memAddr,
    output logic [31:0]   memWrData,
    input  logic [31:0]   memDataOut
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    req_id_t         id_q;
    logic [AW-1:0]   addr_q;
    logic [2:0]      type_q;
    logic            we_q;
    logic [31:0]     wdata_q;
    logic            err_q;
    logic [31:0]     if_rdata_q, ls_rdata_q;
    logic [1:0]      gnt;
    logic            grant_en, ls_bad, ls_bad_gnt, access_done;

    // Gating with rst_n keeps the combinational grants low while reset is held.
    assign grant_en    = (state == S_IDLE) && rst_n;
    assign ls_bad      = ls_access_err(ls_we, ls_type, ls_addr[1:0]);
    assign ls_bad_gnt  = gnt[1] && ls_bad;
    assign access_done = (state == S_ACCESS) && (cnt == '0);

    rr_arb2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (grant_en),
        .req   ({ls_req, if_req}),
        .gnt   (gnt)
    );

    assign if_gnt   = gnt[0];
    assign ls_gnt   = gnt[1];
    assign if_rdata = if_rdata_q;
    assign ls_rdata = ls_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        memType   = 3'b000;
        memAddr   = 32'h0;
        memWrData = 32'h0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        ls_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (ls_bad_gnt) state_nxt = S_RESP;
                else if (|gnt)  state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                memRead   = !we_q;
                memWrite  = we_q;
                memType   = type_q;
                memAddr   = 32'(addr_q);
                memWrData = wdata_q;
                if (cnt == '0) state_nxt = S_RESP;
            end
            S_RESP: begin
                if_rvalid = (id_q == REQ_IF);
                ls_rvalid = (id_q == REQ_LS);
                ls_err    = (id_q == REQ_LS) && err_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            id_q       <= REQ_IF;
            addr_q     <= '0;
            type_q     <= 3'b000;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0;
            err_q      <= 1'b0;
            if_rdata_q <= 32'h0;
            ls_rdata_q <= 32'h0;
        end else begin
            if (|gnt) begin
                id_q    <= gnt[1] ? REQ_LS : REQ_IF;
                addr_q  <= gnt[1] ? ls_addr : if_addr;
                type_q  <= gnt[1] ? ls_type : MT_W;
                we_q    <= gnt[1] && ls_we;
                wdata_q <= gnt[1] ? ls_wdata : 32'h0;
                err_q   <= ls_bad_gnt;
                cnt     <= CW'(MEM_LAT - 1);
                if (ls_bad_gnt) ls_rdata_q <= 32'h0;
            end else if (state == S_ACCESS && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            // Stores report zero data; fetch and load capture the memory word on the last cycle.
            if (access_done) begin
                if (id_q == REQ_IF) if_rdata_q <= memDataOut;
                else                ls_rdata_q <= we_q ? 32'h0 : memDataOut;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (MEM_LAT 1, 3, 4) each with a byte-addressed memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk, rst_n;
    logic        if_req [3];
    logic [31:0] if_addr [3];
    logic        if_gnt [3];
    logic        if_rvalid [3];
    logic [31:0] if_rdata [3];
    logic        ls_req [3];
    logic        ls_we [3];
    logic [2:0]  ls_type [3];
    logic [31:0] ls_addr [3];
    logic [31:0] ls_wdata [3];
    logic        ls_gnt [3];
    logic        ls_rvalid [3];
    logic [31:0] ls_rdata [3];
    logic        ls_err [3];
    logic        memRead [3];
    logic        memWrite [3];
    logic [2:0]  memType [3];
    logic [31:0] memAddr [3];
    logic [31:0] memWrData [3];
    logic [31:0] memDataOut [3];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          t_rv;
        int          n_rd;
        int          n_wr;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          we;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
    } op_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        logic [7:0]  mem [256];
        logic [7:0]  a;
        logic [31:0] rdat;

        mem_arbiter #(.MEM_LAT(LAT), .AW(32)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
            .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
            .ls_req(ls_req[g]), .ls_we(ls_we[g]), .ls_type(ls_type[g]),
            .ls_addr(ls_addr[g]), .ls_wdata(ls_wdata[g]), .ls_gnt(ls_gnt[g]),
            .ls_rvalid(ls_rvalid[g]), .ls_rdata(ls_rdata[g]), .ls_err(ls_err[g]),
            .memRead(memRead[g]), .memWrite(memWrite[g]), .memType(memType[g]),
            .memAddr(memAddr[g]), .memWrData(memWrData[g]), .memDataOut(memDataOut[g])
        );

        assign a = memAddr[g][7:0];

        always_comb begin
            rdat = 32'h0;
            case (memType[g])
                MT_B:    rdat = {{24{mem[a][7]}}, mem[a]};
                MT_BU:   rdat = {24'h0, mem[a]};
                MT_H:    rdat = {{16{mem[a+8'd1][7]}}, mem[a+8'd1], mem[a]};
                MT_HU:   rdat = {16'h0, mem[a+8'd1], mem[a]};
                default: rdat = {mem[a+8'd3], mem[a+8'd2], mem[a+8'd1], mem[a]};
            endcase
        end
        assign memDataOut[g] = rdat;

        always @(posedge clk) begin
            if (memWrite[g]) begin
                mem[a] <= memWrData[g][7:0];
                if (memType[g] != MT_B) mem[a+8'd1] <= memWrData[g][15:8];
                if (memType[g] == MT_W) begin
                    mem[a+8'd2] <= memWrData[g][23:16];
                    mem[a+8'd3] <= memWrData[g][31:24];
                end
            end
        end
    end

    // Drives one request on instance d and records what the DUT does until the response.
    task automatic run_op(input int d, input bit ls, input bit we, input logic [2:0] typ,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int t_gnt, output int t_rd, output int n_rd, output int n_wr,
                          output int t_rv, output logic [31:0] rdata, output logic err,
                          output logic [31:0] m_addr, output logic [2:0] m_type);
        t_gnt = -1; t_rd = -1; n_rd = 0; n_wr = 0; t_rv = -1;
        rdata = 32'hx; err = 1'bx; m_addr = 32'hx; m_type = 3'bx;
        @(negedge clk);
        if (ls) begin
            ls_req[d] = 1'b1; ls_we[d] = we; ls_type[d] = typ;
            ls_addr[d] = addr; ls_wdata[d] = wdata;
        end else begin
            if_req[d] = 1'b1; if_addr[d] = addr;
        end
        for (int c = 0; c < 40 && t_rv < 0; c++) begin
            #1;
            if (t_gnt < 0 && (ls ? ls_gnt[d] : if_gnt[d])) t_gnt = c;
            if (memRead[d])  n_rd++;
            if (memWrite[d]) n_wr++;
            if (t_rd < 0 && (memRead[d] || memWrite[d])) begin
                t_rd = c; m_addr = memAddr[d]; m_type = memType[d];
            end
            if (ls ? ls_rvalid[d] : if_rvalid[d]) begin
                t_rv  = c;
                rdata = ls ? ls_rdata[d] : if_rdata[d];
                err   = ls ? ls_err[d] : 1'b0;
            end
            @(negedge clk);
            if (t_gnt >= 0) begin
                if (ls) ls_req[d] = 1'b0;
                else    if_req[d] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req[0] = 1'b1; ls_req[0] = 1'b1; ls_type[0] = MT_W;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({if_gnt[0], ls_gnt[0]} !== 2'b00) begin
            n_fail++; $display("FAIL reset_gnt: got %b expected 00", {if_gnt[0], ls_gnt[0]});
        end
        n_checks++;
        if ({memRead[0], memWrite[0], memType[0], memAddr[0], memWrData[0]} !== 69'h0) begin
            n_fail++; $display("FAIL reset_mem_outputs: rd=%b wr=%b addr=%h expected all zero",
                               memRead[0], memWrite[0], memAddr[0]);
        end
        n_checks++;
        if ({if_rvalid[0], ls_rvalid[0], ls_err[0], if_rdata[0], ls_rdata[0]} !== 67'h0) begin
            n_fail++; $display("FAIL reset_resp_outputs: if_rdata=%h ls_rdata=%h expected 0",
                               if_rdata[0], ls_rdata[0]);
        end
        if_req[0] = 1'b0; ls_req[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_fetch();
        int t_gnt, t_rd, n_rd, n_wr, t_rv;
        logic [31:0] rdata, m_addr;
        logic [2:0] m_type;
        logic err;
        exp_t e;
        run_op(0, 1'b1, 1'b1, MT_W, 32'h10, 32'hDEADBEEF, t_gnt, t_rd, n_rd, n_wr, t_rv, rdata, err, m_addr, m_type);
        n_checks++;
        if ({t_gnt, n_wr, n_rd, t_rv} !== {32'sd0, 32'sd1, 32'sd0, 32'sd2}) begin
            n_fail++; $display("FAIL preload_store_timing: gnt=%0d wr=%0d rd=%0d rv=%0d expected 0 1 0 2",
                               t_gnt, n_wr, n_rd, t_rv);
        end
        sb.push_back('{32'hDEADBEEF, 1'b0, 2, 1, 0});
        run_op(0, 1'b0, 1'b0, MT_W, 32'h10, 32'h0, t_gnt, t_rd, n_rd, n_wr, t_rv, rdata, err, m_addr, m_type);
        e = sb.pop_front();
        n_checks++;
        if (t_gnt !== 0 || t_rd !== 1) begin
            n_fail++; $display("FAIL fetch_gnt_timing: gnt=%0d first_rd=%0d expected 0 1", t_gnt, t_rd);
        end
        n_checks++;
        if ({n_rd, n_wr, t_rv} !== {e.n_rd, e.n_wr, e.t_rv}) begin
            n_fail++; $display("FAIL fetch_strobes: rd=%0d wr=%0d rv=%0d expected %0d %0d %0d",
                               n_rd, n_wr, t_rv, e.n_rd, e.n_wr, e.t_rv);
        end
        n_checks++;
        if ({m_addr, m_type} !== {32'h10, MT_W}) begin
            n_fail++; $display("FAIL fetch_mem_addr_type: got %h/%b expected 00000010/010", m_addr, m_type);
        end
        n_checks++;
        if (rdata !== e.rdata) begin
            n_fail++; $display("FAIL fetch_rdata: got %h expected %h", rdata, e.rdata);
        end
    endtask

    task automatic test_round_robin();
        req_id_t exp_id[$];
        int exp_t_q[$];
        req_id_t got, want;
        int want_t;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        exp_id  = '{REQ_IF, REQ_LS, REQ_IF, REQ_LS};
        exp_t_q = '{0, 3, 6, 9};
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        ls_req[0] = 1'b1; ls_we[0] = 1'b0; ls_type[0] = MT_W; ls_addr[0] = 32'h10;
        for (int c = 0; c < 30 && exp_id.size() > 0; c++) begin
            #1;
            n_checks++;
            if ((if_gnt[0] & ls_gnt[0]) !== 1'b0) begin
                n_fail++; $display("FAIL rr_double_grant: both grants high at cycle %0d", c);
            end
            if (if_gnt[0] || ls_gnt[0]) begin
                got    = ls_gnt[0] ? REQ_LS : REQ_IF;
                want   = exp_id.pop_front();
                want_t = exp_t_q.pop_front();
                n_checks++;
                if (got !== want || c !== want_t) begin
                    n_fail++; $display("FAIL rr_order: got id=%0d at %0d expected id=%0d at %0d",
                                       got, c, want, want_t);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (exp_id.size() !== 0) begin
            n_fail++; $display("FAIL rr_timeout: %0d grants missing expected 0", exp_id.size());
        end
        if_req[0] = 1'b0; ls_req[0] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_ls_mem();
        op_t ops[$];
        op_t o;
        exp_t e;
        int t_gnt, t_rd, n_rd, n_wr, t_rv;
        logic [31:0] rdata, m_addr;
        logic [2:0] m_type;
        logic err;
        ops.push_back('{1'b1, MT_W,  32'h20, 32'h000000F0, 32'h0,        1'b0});
        ops.push_back('{1'b0, MT_BU, 32'h20, 32'h0,        32'h000000F0, 1'b0});
        ops.push_back('{1'b1, MT_B,  32'h31, 32'hAAAA5580, 32'h0,        1'b0});
        ops.push_back('{1'b0, MT_B,  32'h31, 32'h0,        32'hFFFFFF80, 1'b0});
        ops.push_back('{1'b0, MT_BU, 32'h31, 32'h0,        32'h00000080, 1'b0});
        ops.push_back('{1'b1, MT_BU, 32'h20, 32'h12345678, 32'h0,        1'b1});
        ops.push_back('{1'b0, MT_W,  32'h20, 32'h0,        32'h000000F0, 1'b0});
        foreach (ops[i]) begin
            o = ops[i];
            sb.push_back('{o.rdata, o.err, o.err ? 1 : 4,
                           (!o.we && !o.err) ? 3 : 0, (o.we && !o.err) ? 3 : 0});
            run_op(1, 1'b1, o.we, o.typ, o.addr, o.wdata, t_gnt, t_rd, n_rd, n_wr, t_rv, rdata, err, m_addr, m_type);
            e = sb.pop_front();
            n_checks++;
            if ({t_gnt, t_rv, n_rd, n_wr} !== {32'sd0, e.t_rv, e.n_rd, e.n_wr}) begin
                n_fail++; $display("FAIL lat3_op%0d_timing: gnt=%0d rv=%0d rd=%0d wr=%0d expected 0 %0d %0d %0d",
                                   i, t_gnt, t_rv, n_rd, n_wr, e.t_rv, e.n_rd, e.n_wr);
            end
            n_checks++;
            if ({rdata, err} !== {e.rdata, e.err}) begin
                n_fail++; $display("FAIL lat3_op%0d_data: got %h err=%b expected %h err=%b",
                                   i, rdata, err, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_ls_errors();
        op_t ops[$];
        op_t o;
        exp_t e;
        int t_gnt, t_rd, n_rd, n_wr, t_rv;
        logic [31:0] rdata, m_addr;
        logic [2:0] m_type;
        logic err;
        ops.push_back('{1'b0, MT_W,   32'h22, 32'h0,        32'h0,        1'b1});
        ops.push_back('{1'b1, MT_H,   32'h22, 32'h12348001, 32'h0,        1'b0});
        ops.push_back('{1'b0, MT_H,   32'h22, 32'h0,        32'hFFFF8001, 1'b0});
        ops.push_back('{1'b0, MT_H,   32'h21, 32'h0,        32'h0,        1'b1});
        ops.push_back('{1'b0, MT_HU,  32'h22, 32'h0,        32'h00008001, 1'b0});
        ops.push_back('{1'b0, MT_HU,  32'h23, 32'h0,        32'h0,        1'b1});
        ops.push_back('{1'b0, 3'b011, 32'h20, 32'h0,        32'h0,        1'b1});
        ops.push_back('{1'b1, 3'b110, 32'h20, 32'h0,        32'h0,        1'b1});
        ops.push_back('{1'b1, MT_HU,  32'h22, 32'h0,        32'h0,        1'b1});
        ops.push_back('{1'b1, MT_W,   32'h21, 32'h0,        32'h0,        1'b1});
        foreach (ops[i]) begin
            o = ops[i];
            sb.push_back('{o.rdata, o.err, o.err ? 1 : 2,
                           (!o.we && !o.err) ? 1 : 0, (o.we && !o.err) ? 1 : 0});
            run_op(0, 1'b1, o.we, o.typ, o.addr, o.wdata, t_gnt, t_rd, n_rd, n_wr, t_rv, rdata, err, m_addr, m_type);
            e = sb.pop_front();
            n_checks++;
            if ({t_gnt, t_rv, n_rd, n_wr} !== {32'sd0, e.t_rv, e.n_rd, e.n_wr}) begin
                n_fail++; $display("FAIL chk_op%0d_timing: gnt=%0d rv=%0d rd=%0d wr=%0d expected 0 %0d %0d %0d",
                                   i, t_gnt, t_rv, n_rd, n_wr, e.t_rv, e.n_rd, e.n_wr);
            end
            n_checks++;
            if ({rdata, err} !== {e.rdata, e.err}) begin
                n_fail++; $display("FAIL chk_op%0d_data: got %h err=%b expected %h err=%b",
                                   i, rdata, err, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_reset_midop();
        int rv_seen = 0;
        int t_gnt, t_rd, n_rd, n_wr, t_rv;
        logic [31:0] rdata, m_addr;
        logic [2:0] m_type;
        logic err;
        @(negedge clk);
        if_req[2] = 1'b1; if_addr[2] = 32'h40;
        #1;
        n_checks++;
        if (if_gnt[2] !== 1'b1) begin
            n_fail++; $display("FAIL midop_gnt: got %b expected 1", if_gnt[2]);
        end
        @(negedge clk); if_req[2] = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (memRead[2] !== 1'b1) begin
            n_fail++; $display("FAIL midop_in_access: memRead=%b expected 1", memRead[2]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({memRead[2], memWrite[2], memType[2], memAddr[2], if_rvalid[2], if_rdata[2]} !== 70'h0) begin
            n_fail++; $display("FAIL midop_reset_outputs: rd=%b addr=%h rdata=%h expected all zero",
                               memRead[2], memAddr[2], if_rdata[2]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (if_rvalid[2] || ls_rvalid[2]) rv_seen++;
            @(negedge clk);
        end
        n_checks++;
        if (rv_seen !== 0) begin
            n_fail++; $display("FAIL midop_no_rvalid: got %0d pulses expected 0", rv_seen);
        end
        run_op(2, 1'b0, 1'b0, MT_W, 32'h40, 32'h0, t_gnt, t_rd, n_rd, n_wr, t_rv, rdata, err, m_addr, m_type);
        n_checks++;
        if ({t_gnt, t_rd, n_rd, t_rv} !== {32'sd0, 32'sd1, 32'sd4, 32'sd5}) begin
            n_fail++; $display("FAIL lat4_fetch_timing: gnt=%0d first_rd=%0d rd=%0d rv=%0d expected 0 1 4 5",
                               t_gnt, t_rd, n_rd, t_rv);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if_req[i] = 1'b0; if_addr[i] = 32'h0;
            ls_req[i] = 1'b0; ls_we[i] = 1'b0; ls_type[i] = MT_W;
            ls_addr[i] = 32'h0; ls_wdata[i] = 32'h0;
        end
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_ls_mem();
        test_ls_errors();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
